// File: rtl/sram_config_loader_pkg.sv
// Shared state encodings for the serial configuration loader.
// The FSM enum is pinned to these 3-bit codes so other blocks can decode state.
package fpga_cfg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    WRITE  = ST_WRITE,
    PARITY = ST_PARITY,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/sram_config_loader_if.sv
// Serial config stream in, sram write port and status out.
// master = host/sram side, slave = loader.
interface sram_config_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) ();

  logic                  cfg_start;
  logic                  cfg_valid;
  logic                  cfg_bit;
  logic                  cfg_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    input  cfg_ready, waddr, wdata, we, busy, done, err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    output cfg_ready, waddr, wdata, we, busy, done, err
  );

endinterface

// File: rtl/sram_config_loader.sv
// Deserialises a config bitstream into 2**ADDR_WIDTH sram words, then checks
// a trailing even-parity bit over the whole frame.
module sram_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_config_loader_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q, waddr_q;
  logic [DATA_WIDTH-1:0] shift_q, wdata_q, word_nxt;
  logic                  parity_q, err_q;
  logic                  ready, we, busy;
  logic                  accept, last_bit, last_addr;

  assign accept    = bus.cfg_valid && ready;
  // Truncating cast keeps the low DATA_WIDTH bits, so this also works for DATA_WIDTH=1.
  assign word_nxt  = DATA_WIDTH'({shift_q, bus.cfg_bit});
  assign last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign last_addr = &addr_q;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    we      = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:   if (bus.cfg_start) state_d = SHIFT;
      SHIFT: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && last_bit) state_d = WRITE;
      end
      WRITE: begin
        we      = 1'b1;
        busy    = 1'b1;
        state_d = last_addr ? PARITY : SHIFT;
      end
      PARITY: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) state_d = DONE;
      end
      DONE:   if (bus.cfg_start) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      waddr_q   <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      parity_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (bus.cfg_start) begin
            bit_cnt_q <= '0;
            addr_q    <= '0;
            parity_q  <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        SHIFT: begin
          if (accept) begin
            shift_q  <= word_nxt;
            parity_q <= parity_q ^ bus.cfg_bit;
            // waddr/wdata only move here so the sram port is stable outside WRITE.
            if (last_bit) begin
              bit_cnt_q <= '0;
              wdata_q   <= word_nxt;
              waddr_q   <= addr_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        WRITE:  if (!last_addr) addr_q <= addr_q + ADDR_WIDTH'(1);
        PARITY: if (accept) err_q <= parity_q ^ bus.cfg_bit;
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready = ready;
  assign bus.we        = we;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_sram_config_loader.sv
// Directed bench: default loader (16x1) with an sram write log, plus a 4x4
// instance for word assembly order.
module tb_sram_config_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_config_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(1)) bus ();
  sram_config_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) b4 ();

  sram_config_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_config_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // sram model and write log
  logic mem [16];
  int   wcnt = 0, bad_addr = 0, bad_we = 0;
  bit   acc_d = 1'b0;
  int   w4cnt = 0;
  logic [3:0] w4data;
  logic [1:0] w4addr;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (bus.waddr !== 4'(wcnt)) bad_addr++;
      if (!acc_d) bad_we++;
      mem[bus.waddr] = bus.wdata[0];
      wcnt++;
    end
    acc_d = (bus.cfg_valid === 1'b1) && (bus.cfg_ready === 1'b1);
    if (b4.we === 1'b1) begin
      if (w4cnt == 0) begin
        w4data = b4.wdata;
        w4addr = b4.waddr;
      end
      w4cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wcnt = 0;
    bad_addr = 0;
    bad_we = 0;
    for (int i = 0; i < 16; i++) mem[i] = 1'bx;
  endtask

  task automatic send_bit(logic b, bit gaps);
    int guard;
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.cfg_valid = 1'b0;
      tick();
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = b;
    guard = 0;
    while (bus.cfg_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'd1, 32'd0);
    else tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic run_frame(logic par, bit gaps, int mid_start_at);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == mid_start_at) bus.cfg_start = 1'b1;
      send_bit((i % 2) == 0, gaps);
      bus.cfg_start = 1'b0;
    end
    send_bit(par, gaps);
    tick();
  endtask

  // Stream 1,0,1,0,... puts 1 at even addresses: 16'h5555 with mem[0] as bit 0.
  task automatic check_frame(string tag, logic exp_err);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mem[i];
    chk({tag, "_done"},     32'(bus.done), 32'd1);
    chk({tag, "_err"},      32'(bus.err),  32'(exp_err));
    chk({tag, "_wcnt"},     32'(wcnt),     32'd16);
    chk({tag, "_addr_seq"}, 32'(bad_addr), 32'd0);
    chk({tag, "_we_stall"}, 32'(bad_we),   32'd0);
    chk({tag, "_mem"},      32'(v),        32'h5555);
  endtask

  initial begin
    logic [3:0] pat;
    int guard;
    rst = 1'b1;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    b4.cfg_start  = 1'b0; b4.cfg_valid  = 1'b0; b4.cfg_bit  = 1'b0;
    clear_log();
    tick();
    tick();
    chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_we",    32'(bus.we),        32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_err",   32'(bus.err),       32'd0);
    chk("rst_waddr", 32'(bus.waddr),     32'd0);
    chk("rst_wdata", 32'(bus.wdata),     32'd0);
    rst = 1'b0;
    tick();

    // good parity
    clear_log();
    run_frame(1'b0, 1'b0, -1);
    check_frame("t1", 1'b0);

    // bad parity
    clear_log();
    run_frame(1'b1, 1'b0, -1);
    check_frame("t2", 1'b1);

    // random valid gaps
    clear_log();
    run_frame(1'b0, 1'b1, -1);
    check_frame("t3", 1'b0);

    // reset after 5 words, then reload from address 0
    clear_log();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) send_bit((i % 2) == 0, 1'b0);
    tick();
    chk("t4_pre_wcnt", 32'(wcnt),     32'd5);
    chk("t4_pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("t4_rst_we",    32'(bus.we),        32'd0);
    chk("t4_rst_busy",  32'(bus.busy),      32'd0);
    chk("t4_rst_waddr", 32'(bus.waddr),     32'd0);
    chk("t4_rst_ready", 32'(bus.cfg_ready), 32'd0);
    chk("t4_rst_done",  32'(bus.done),      32'd0);
    rst = 1'b0;
    tick();
    clear_log();
    run_frame(1'b0, 1'b0, -1);
    check_frame("t4", 1'b0);

    // start pulse mid-frame is ignored
    clear_log();
    run_frame(1'b0, 1'b0, 8);
    check_frame("t5", 1'b0);

    // 4-bit words: first bit is the MSB
    pat = 4'b1011;
    b4.cfg_start = 1'b1;
    tick();
    b4.cfg_start = 1'b0;
    chk("t6_ready", 32'(b4.cfg_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      b4.cfg_valid = 1'b1;
      b4.cfg_bit   = pat[3-k];
      tick();
    end
    b4.cfg_valid = 1'b0;
    guard = 0;
    while (w4cnt == 0 && guard < 10) begin
      tick();
      guard++;
    end
    chk("t6_wcnt",  32'(w4cnt),  32'd1);
    chk("t6_wdata", 32'(w4data), 32'hB);
    chk("t6_waddr", 32'(w4addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_config_loader.md
SRAM_CONFIG_LOADER -- requirements
Module: sram_config_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address width of the downstream sram; the frame is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 1: word width of the downstream sram; each word is DATA_WIDTH serial bits.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1: reset; synchronous, active-high.
REQ-005 Port cfg_start  input  1: start pulse; begins loading a frame.
REQ-006 Port cfg_valid  input  1: cfg_bit carries a valid serial bit.
REQ-007 Port cfg_bit  input  1: serial configuration bit.
REQ-008 Port cfg_ready  output  1: loader accepts a bit this cycle.
REQ-009 Port waddr  output  ADDR_WIDTH: sram write address.
REQ-010 Port wdata  output  DATA_WIDTH: sram write data.
REQ-011 Port we  output  1: sram write enable, one-cycle pulse per word.
REQ-012 Port busy  output  1: high in SHIFT, WRITE and PARITY.
REQ-013 Port done  output  1: frame complete; held until restart or reset.
REQ-014 Port err  output  1: parity mismatch on the last frame; valid while done=1.

Function
REQ-015 States SHALL be IDLE, SHIFT, WRITE, PARITY, DONE.
REQ-016 A bit SHALL be accepted only in a cycle with cfg_valid=1 and cfg_ready=1.
REQ-017 cfg_ready SHALL be 1 in SHIFT and PARITY and 0 in every other state.
REQ-018 IDLE->SHIFT on cfg_start=1: clear the bit counter, word address, parity accumulator, done and err.
REQ-019 DONE->SHIFT on cfg_start=1, with the same clearing as REQ-018.
REQ-020 cfg_start SHALL be ignored in SHIFT, WRITE and PARITY.
REQ-021 SHIFT: each accepted bit SHALL shift into the word register MSB-first, so the first bit lands in wdata[DATA_WIDTH-1].
REQ-022 SHIFT: the parity accumulator SHALL XOR in each accepted bit.
REQ-023 SHIFT->WRITE in the cycle the DATA_WIDTH-th bit of a word is accepted.
REQ-024 WRITE lasts exactly one cycle, with we=1, waddr = current word address and wdata = the assembled word.
REQ-025 WRITE->SHIFT with the address incremented, unless the address equals 2**ADDR_WIDTH-1.
REQ-026 WRITE->PARITY when the address equals 2**ADDR_WIDTH-1; the address SHALL NOT wrap.
REQ-027 PARITY accepts one bit; the frame uses even parity over all data bits plus the parity bit.
REQ-028 PARITY->DONE on acceptance of that bit; err = accumulator XOR cfg_bit; done=1.
REQ-029 Latency: we SHALL rise in the cycle after the last bit of a word is accepted.
REQ-030 Cycles with cfg_valid=0 SHALL stall the loader with no state change.
REQ-031 we SHALL be 0 in every state except WRITE.
REQ-032 waddr and wdata SHALL hold their values outside WRITE.
REQ-033 Exactly 2**ADDR_WIDTH write pulses SHALL occur per completed frame.

Reset
REQ-034 rst=1 at a clock edge SHALL force: IDLE, cfg_ready=0, we=0, busy=0, done=0, err=0, waddr=0, wdata=0, bit counter=0, parity=0.
REQ-035 rst SHALL take priority over cfg_start and cfg_valid.
REQ-036 Reset mid-frame SHALL abort the frame; words already written to the sram are not erased.

Structure
REQ-037 The state encodings SHALL live in the shared package fpga_cfg_pkg, as 3-bit localparams.
REQ-038 No sub-module is required; the shift register, counters and FSM are inline.
REQ-039 The loader SHALL connect directly to sram ports waddr, wdata and we, with matching ADDR_WIDTH and DATA_WIDTH.

Verification
REQ-040 Defaults; start; 16 bits 1,0,1,0,... then parity 0 -> 16 we pulses at addresses 0..15; sram reads 1,0,1,0,...; done=1, err=0.
REQ-041 Same stream with parity bit 1 -> done=1, err=1; sram contents as in REQ-040.
REQ-042 Random cfg_valid gaps (50% duty) on the REQ-040 stream -> identical writes and result; no we pulse while stalled.
REQ-043 rst=1 after 5 words written -> next cycle: we=0, busy=0, waddr=0, cfg_ready=0; a fresh start then reloads from address 0.
REQ-044 cfg_start pulsed mid-frame -> ignored, write count still 16; DATA_WIDTH=4 with bits 1,0,1,1 -> first write wdata=4'b1011 at waddr 0.
